// File: rtl/obj_motion_ctl_if.sv
// Load channel and position/status bus between game logic and one motion engine.
interface obj_motion_ctl_if #(
  parameter int unsigned XW = 11,
  parameter int unsigned YW = 10,
  parameter int unsigned VW = 6
);
  logic          load_valid;
  logic          load_ready;
  logic [XW-1:0] load_x;
  logic [YW-1:0] load_y;
  logic [VW-1:0] load_vx;
  logic [VW-1:0] load_vy;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic [VW-1:0] vel_x;
  logic [VW-1:0] vel_y;
  logic          pos_valid;
  logic [3:0]    hit;

  // Game logic side: issues loads, consumes position updates.
  modport master (
    output load_valid, load_x, load_y, load_vx, load_vy,
    input  load_ready, pos_x, pos_y, vel_x, vel_y, pos_valid, hit
  );

  // Motion engine side.
  modport slave (
    input  load_valid, load_x, load_y, load_vx, load_vy,
    output load_ready, pos_x, pos_y, vel_x, vel_y, pos_valid, hit
  );
endinterface

// File: rtl/obj_motion_ctl.sv
// Per-sprite position engine: one clamp/bounce/wrap motion step per frame tick.
module obj_motion_ctl #(
  parameter int unsigned SCREEN_W = 1024,
  parameter int unsigned SCREEN_H = 768,
  parameter int unsigned XW       = 11,
  parameter int unsigned YW       = 10,
  parameter int unsigned VW       = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic [1:0]        mode,
  input  logic [XW-1:0]     obj_w,
  input  logic [YW-1:0]     obj_h,
  output logic              tick_overrun,
  obj_motion_ctl_if.slave   bus
);

  localparam int unsigned XS = XW + 1;
  localparam int unsigned YS = YW + 1;

  localparam logic [1:0] M_BOUNCE = 2'd1;
  localparam logic [1:0] M_WRAP   = 2'd2;
  localparam logic [1:0] M_FREEZE = 2'd3;

  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y} state_t;

  state_t        state;
  logic [1:0]    mode_q;
  logic [XW-1:0] w_q;
  logic [YW-1:0] h_q;
  logic [1:0]    hit_x_q;

  // Largest legal top-left coordinate; oversized objects pin to 0.
  function automatic logic [XW-1:0] lim_x(input logic [XW-1:0] w);
    return (w >= XW'(SCREEN_W)) ? '0 : XW'(SCREEN_W) - w;
  endfunction

  function automatic logic [YW-1:0] lim_y(input logic [YW-1:0] h);
    return (h >= YW'(SCREEN_H)) ? '0 : YW'(SCREEN_H) - h;
  endfunction

  // Velocity reversal; the most negative value has no positive twin, so saturate.
  function automatic logic [VW-1:0] neg_sat(input logic [VW-1:0] v);
    return (v == {1'b1, {(VW-1){1'b0}}}) ? {1'b0, {(VW-1){1'b1}}} : -v;
  endfunction

  logic [XW-1:0]        max_x, new_x, ld_max_x, ld_x;
  logic [YW-1:0]        max_y, new_y, ld_max_y, ld_y;
  logic [VW-1:0]        new_vx, new_vy;
  logic signed [XS-1:0] nx, wx, lx_s;
  logic signed [YS-1:0] ny, wy, ly_s;
  logic                 lo_x, hi_x, lo_y, hi_y;

  // X-axis step result from the latched mode/width.
  always_comb begin
    max_x  = lim_x(w_q);
    lx_s   = $signed({1'b0, max_x});
    nx     = $signed({1'b0, bus.pos_x}) + XS'($signed(bus.vel_x));
    lo_x   = nx[XW];
    hi_x   = !nx[XW] && (nx > lx_s);
    wx     = nx;
    new_vx = bus.vel_x;
    if (mode_q == M_WRAP) begin
      if (lo_x)      wx = nx + lx_s + $signed(XS'(1));
      else if (hi_x) wx = nx - lx_s - $signed(XS'(1));
      new_x = wx[XW] ? '0 : ((wx > lx_s) ? max_x : wx[XW-1:0]);
    end else begin
      new_x = lo_x ? '0 : (hi_x ? max_x : nx[XW-1:0]);
      if ((mode_q == M_BOUNCE) && (lo_x || hi_x)) new_vx = neg_sat(bus.vel_x);
    end
  end

  // Y-axis step result from the latched mode/height.
  always_comb begin
    max_y  = lim_y(h_q);
    ly_s   = $signed({1'b0, max_y});
    ny     = $signed({1'b0, bus.pos_y}) + YS'($signed(bus.vel_y));
    lo_y   = ny[YW];
    hi_y   = !ny[YW] && (ny > ly_s);
    wy     = ny;
    new_vy = bus.vel_y;
    if (mode_q == M_WRAP) begin
      if (lo_y)      wy = ny + ly_s + $signed(YS'(1));
      else if (hi_y) wy = ny - ly_s - $signed(YS'(1));
      new_y = wy[YW] ? '0 : ((wy > ly_s) ? max_y : wy[YW-1:0]);
    end else begin
      new_y = lo_y ? '0 : (hi_y ? max_y : ny[YW-1:0]);
      if ((mode_q == M_BOUNCE) && (lo_y || hi_y)) new_vy = neg_sat(bus.vel_y);
    end
  end

  // Loaded position is clamped against the live object size.
  always_comb begin
    ld_max_x = lim_x(obj_w);
    ld_max_y = lim_y(obj_h);
    ld_x     = (bus.load_x > ld_max_x) ? ld_max_x : bus.load_x;
    ld_y     = (bus.load_y > ld_max_y) ? ld_max_y : bus.load_y;
  end

  // Step sequencer, load handling and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mode_q         <= '0;
      w_q            <= '0;
      h_q            <= '0;
      hit_x_q        <= '0;
      tick_overrun   <= 1'b0;
      bus.load_ready <= 1'b0;
      bus.pos_x      <= '0;
      bus.pos_y      <= '0;
      bus.vel_x      <= '0;
      bus.vel_y      <= '0;
      bus.pos_valid  <= 1'b0;
      bus.hit        <= '0;
    end else begin
      bus.pos_valid <= 1'b0;
      case (state)
        IDLE: begin
          bus.load_ready <= 1'b1;
          if (bus.load_valid && bus.load_ready) begin
            bus.pos_x    <= ld_x;
            bus.pos_y    <= ld_y;
            bus.vel_x    <= bus.load_vx;
            bus.vel_y    <= bus.load_vy;
            bus.hit      <= '0;
            tick_overrun <= 1'b0;
          end else if (frame_tick) begin
            mode_q <= mode;
            w_q    <= obj_w;
            h_q    <= obj_h;
            if (mode == M_FREEZE) begin
              bus.pos_valid <= 1'b1;
              bus.hit       <= '0;
            end else begin
              state          <= STEP_X;
              bus.load_ready <= 1'b0;
            end
          end
        end
        STEP_X: begin
          if (frame_tick) tick_overrun <= 1'b1;
          bus.pos_x <= new_x;
          bus.vel_x <= new_vx;
          hit_x_q   <= {lo_x, hi_x};
          state     <= STEP_Y;
        end
        STEP_Y: begin
          if (frame_tick) tick_overrun <= 1'b1;
          bus.pos_y      <= new_y;
          bus.vel_y      <= new_vy;
          bus.hit        <= {lo_y, hi_y, hit_x_q};
          bus.pos_valid  <= 1'b1;
          bus.load_ready <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obj_motion_ctl.sv
// Randomized bench for obj_motion_ctl against an integer-arithmetic reference model.
module tb_obj_motion_ctl;

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned VW = 6;
  localparam int SW = 1024;
  localparam int SH = 768;

  logic          clk;
  logic          rst_n;
  logic          frame_tick;
  logic [1:0]    mode;
  logic [XW-1:0] obj_w;
  logic [YW-1:0] obj_h;
  logic          tick_overrun;

  obj_motion_ctl_if #(.XW(XW), .YW(YW), .VW(VW)) bus ();

  obj_motion_ctl #(
    .SCREEN_W(1024), .SCREEN_H(768), .XW(XW), .YW(YW), .VW(VW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .mode         (mode),
    .obj_w        (obj_w),
    .obj_h        (obj_h),
    .tick_overrun (tick_overrun),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model state: plain integers, velocities signed.
  int m_px, m_py, m_vx, m_vy, m_hit, m_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lim(input int size, input int screen);
    return (size >= screen) ? 0 : screen - size;
  endfunction

  task automatic model_axis(input int p, input int v, input int l, input int md,
                            output int np, output int nv, output int lo, output int hi);
    int n;
    n  = p + v;
    lo = (n < 0) ? 1 : 0;
    hi = (n > l) ? 1 : 0;
    np = n;
    nv = v;
    if (md == 2) begin
      if (lo != 0)      np = n + l + 1;
      else if (hi != 0) np = n - l - 1;
      if (np < 0)       np = 0;
      else if (np > l)  np = l;
    end else begin
      if (lo != 0)      np = 0;
      else if (hi != 0) np = l;
      if (md == 1 && (lo != 0 || hi != 0)) nv = (v == -32) ? 31 : -v;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pos_x"}, 32'(bus.pos_x), 32'(m_px));
    check({tag, ".pos_y"}, 32'(bus.pos_y), 32'(m_py));
    check({tag, ".vel_x"}, 32'(bus.vel_x), 32'(m_vx & 63));
    check({tag, ".vel_y"}, 32'(bus.vel_y), 32'(m_vy & 63));
    check({tag, ".hit"}, 32'(bus.hit), 32'(m_hit));
    check({tag, ".ovr"}, 32'(tick_overrun), 32'(m_ovr));
  endtask

  task automatic do_load(input int x, input int y, input int vx, input int vy,
                         input int w, input int h, input bit tk, input int md);
    int lx, ly;
    check("load.ready_pre", 32'(bus.load_ready), 32'd1);
    bus.load_valid = 1'b1;
    bus.load_x     = XW'(x);
    bus.load_y     = YW'(y);
    bus.load_vx    = VW'(vx);
    bus.load_vy    = VW'(vy);
    obj_w          = XW'(w);
    obj_h          = YW'(h);
    mode           = 2'(md);
    frame_tick     = tk;
    step();
    bus.load_valid = 1'b0;
    frame_tick     = 1'b0;
    lx    = lim(w, SW);
    ly    = lim(h, SH);
    m_px  = (x > lx) ? lx : x;
    m_py  = (y > ly) ? ly : y;
    m_vx  = vx;
    m_vy  = vy;
    m_hit = 0;
    m_ovr = 0;
    check("load.pv", 32'(bus.pos_valid), 32'd0);
    check_state("load");
    step();
    check("load.pv_next", 32'(bus.pos_valid), 32'd0);
    check("load.ready_post", 32'(bus.load_ready), 32'd1);
  endtask

  // ovr_at: 0 none, 1 extra tick during STEP_X, 2 during STEP_Y.
  task automatic do_tick(input int md, input int w, input int h, input int ovr_at);
    int nx, nvx, xlo, xhi, ny, nvy, ylo, yhi;
    frame_tick = 1'b1;
    mode       = 2'(md);
    obj_w      = XW'(w);
    obj_h      = YW'(h);
    step();
    frame_tick = 1'b0;
    if (md == 3) begin
      m_hit = 0;
      check("freeze.pv", 32'(bus.pos_valid), 32'd1);
      check_state("freeze");
      step();
      check("freeze.pv_end", 32'(bus.pos_valid), 32'd0);
      return;
    end
    model_axis(m_px, m_vx, lim(w, SW), md, nx, nvx, xlo, xhi);
    model_axis(m_py, m_vy, lim(h, SH), md, ny, nvy, ylo, yhi);
    // Disturb live inputs: the step must use values latched at the tick.
    mode           = 2'($urandom);
    obj_w          = XW'($urandom);
    obj_h          = YW'($urandom);
    bus.load_valid = 1'($urandom);
    bus.load_x     = XW'($urandom);
    bus.load_y     = YW'($urandom);
    bus.load_vx    = VW'($urandom);
    bus.load_vy    = VW'($urandom);
    check("tick.pv_e0", 32'(bus.pos_valid), 32'd0);
    check("tick.ready_e0", 32'(bus.load_ready), 32'd0);
    if (ovr_at == 1) frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("tick.pv_e1", 32'(bus.pos_valid), 32'd0);
    check("tick.x_e1", 32'(bus.pos_x), 32'(nx));
    if (ovr_at == 2) frame_tick = 1'b1;
    step();
    frame_tick     = 1'b0;
    bus.load_valid = 1'b0;
    m_px  = nx;
    m_vx  = nvx;
    m_py  = ny;
    m_vy  = nvy;
    m_hit = ylo * 8 + yhi * 4 + xlo * 2 + xhi;
    if (ovr_at != 0) m_ovr = 1;
    check("tick.pv_e2", 32'(bus.pos_valid), 32'd1);
    check_state("tick");
    step();
    check("tick.pv_e3", 32'(bus.pos_valid), 32'd0);
    check("tick.ready_e3", 32'(bus.load_ready), 32'd1);
    check("tick.hit_hold", 32'(bus.hit), 32'(m_hit));
  endtask

  task automatic reset_mid();
    frame_tick = 1'b1;
    mode       = 2'd0;
    step();
    frame_tick = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    m_px = 0; m_py = 0; m_vx = 0; m_vy = 0; m_hit = 0; m_ovr = 0;
    check("rst.pv", 32'(bus.pos_valid), 32'd0);
    check("rst.ready", 32'(bus.load_ready), 32'd0);
    check_state("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("rst.ready_post", 32'(bus.load_ready), 32'd1);
    check("rst.pv_post", 32'(bus.pos_valid), 32'd0);
    check_state("rst_post");
  endtask

  initial begin
    int r, w, h;
    vectors        = 0;
    miscompares    = 0;
    m_px = 0; m_py = 0; m_vx = 0; m_vy = 0; m_hit = 0; m_ovr = 0;
    rst_n          = 1'b0;
    frame_tick     = 1'b0;
    mode           = 2'd0;
    obj_w          = '0;
    obj_h          = '0;
    bus.load_valid = 1'b0;
    bus.load_x     = '0;
    bus.load_y     = '0;
    bus.load_vx    = '0;
    bus.load_vy    = '0;

    step();
    check("reset.ready", 32'(bus.load_ready), 32'd0);
    check("reset.pv", 32'(bus.pos_valid), 32'd0);
    check_state("reset");
    rst_n = 1'b1;
    step();

    // Basic move.
    do_load(100, 50, 5, -3, 32, 32, 1'b0, 0);
    do_tick(0, 32, 32, 0);
    check("tp1.x", 32'(bus.pos_x), 32'd105);
    check("tp1.y", 32'(bus.pos_y), 32'd47);

    // Clamp on the right edge.
    do_load(990, 0, 10, 0, 32, 32, 1'b0, 0);
    do_tick(0, 32, 32, 0);
    check("tp2.x", 32'(bus.pos_x), 32'd992);
    check("tp2.hit", 32'(bus.hit), 32'b0001);
    check("tp2.vx", 32'(bus.vel_x), 32'd10);

    // Bounce off top and left, including the saturating reversal.
    do_load(0, 2, -32, -5, 32, 16, 1'b0, 1);
    do_tick(1, 32, 16, 0);
    check("tp3.y", 32'(bus.pos_y), 32'd0);
    check("tp3.vy", 32'(bus.vel_y), 32'd5);
    check("tp3.vx", 32'(bus.vel_x), 32'd31);
    check("tp3.hit", 32'(bus.hit), 32'b1010);

    // Wrap both directions.
    do_load(998, 100, 7, 0, 24, 16, 1'b0, 2);
    do_tick(2, 24, 16, 0);
    check("tp4.x_r", 32'(bus.pos_x), 32'd4);
    check("tp4.hit_r", 32'(bus.hit), 32'b0001);
    do_load(3, 100, -8, 0, 24, 16, 1'b0, 2);
    do_tick(2, 24, 16, 0);
    check("tp4.x_l", 32'(bus.pos_x), 32'd996);
    check("tp4.hit_l", 32'(bus.hit), 32'b0010);

    // Overrun, load beating a tick, load clamping.
    do_load(100, 100, 1, 1, 32, 32, 1'b0, 0);
    do_tick(0, 32, 32, 1);
    check("tp5.ovr", 32'(tick_overrun), 32'd1);
    do_load(200, 200, 2, 2, 32, 32, 1'b1, 0);
    check("tp5.ovr_clr", 32'(tick_overrun), 32'd0);
    do_load(1020, 10, 0, 0, 32, 32, 1'b0, 0);
    check("tp5.x_clamp", 32'(bus.pos_x), 32'd992);

    // Reset during STEP_Y, then a frozen tick.
    reset_mid();
    do_load(300, 400, 3, 4, 16, 16, 1'b0, 0);
    do_tick(3, 16, 16, 0);
    check("tp6.x", 32'(bus.pos_x), 32'd300);
    check("tp6.y", 32'(bus.pos_y), 32'd400);

    // Random transactions.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 19));
      w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 64));
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 64));
      if (r < 6) begin
        do_load(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
                w, h, 1'($urandom), int'($urandom_range(0, 3)));
      end else if (r < 19) begin
        do_tick(int'($urandom_range(0, 3)), w, h,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0);
      end else begin
        reset_mid();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
